i2s_dac_tx: RTL and testbench
=============================

// Module: i2s_dac_tx
// PURPOSE
//  Downstream audio output stage of the RISC-V filter CPU.
//  - Captures each filtered 32-bit sample the CPU emits (outport, qualified by output_valid) into a FIFO.
//  - Serialises the samples as stereo I2S (BCLK, LRCLK, SDATA) to the DAC.
//  - Decouples CPU program timing from the fixed audio frame rate; reports overflow and underflow.
// PARAMETERS
//  DWIDTH    32  sample word width; [31:16] = left, [15:0] = right; DWIDTH == 2*SAMPLE_W required
//  SAMPLE_W  16  bits per channel, which is also the I2S slot width
//  DEPTH     8   FIFO depth in words, power of 2, >= 2
//  BCLK_DIV  4   clock cycles per BCLK half-period, >= 1
// PORTS
//  clock         in   1               system clock; all logic on posedge
//  reset         in   1               asynchronous, active-low reset
//  outport       in   DWIDTH          sample word from the CPU
//  output_valid  in   1               push strobe; one word is written per cycle high
//  enable        in   1               serialiser run request; sampled at frame boundaries only
//  clr_flags     in   1               clears the sticky status flags
//  i2s_bclk      out  1               bit clock
//  i2s_lrclk     out  1               word select; 0 = left, 1 = right
//  i2s_sdata     out  1               serial data, MSB first
//  fifo_level    out  $clog2(DEPTH)+1 words currently held in the FIFO
//  overflow      out  1               sticky: a push was dropped because the FIFO was full
//  underflow     out  1               sticky: a frame started with the FIFO empty
// BEHAVIOUR
//  Reset (reset=0, asynchronous): all outputs are 0, the FIFO is emptied, divider, bit counter and shifter are cleared, and the state is IDLE.
//  FIFO
//   - First-word-fall-through.
//   - A push in cycle N is visible on fifo_level in cycle N+1.
//   - Push when full with no pop: the word is dropped and overflow is set.
//   - Push and pop in the same cycle when full: both occur, level is unchanged, no overflow.
//   - Push and pop in the same cycle when empty: the push is stored and the pop counts as an underflow.
//  Divider: divcnt counts 0..BCLK_DIV-1 and i2s_bclk toggles at terminal count. A "fall event" is the cycle in which bclk is registered 1 -> 0.
//  States
//   - IDLE: bclk=0, lrclk=0, sdata=0, bitcnt=0. Moves to RUN on the first cycle with enable=1.
//   - RUN: at every fall event, bitcnt increments, wrapping at 2*SAMPLE_W-1 -> 0.
//   - In RUN, lrclk and sdata update only on fall events, so they are stable at bclk rising edges.
//  Frame boundary (the fall event where bitcnt wraps to 0, plus the IDLE->RUN entry)
//   - If enable=0: go to IDLE. The pending right-channel LSB is dropped.
//   - Else, FIFO not empty: pop one word, load shifter = {left, right}, set lrclk=0.
//   - Else, FIFO empty: load shifter = 0 and set underflow.
//  I2S one-bit delay
//   - In slot 0, sdata = LSB of the previous frame (0 after IDLE).
//   - In slots 1..2*SAMPLE_W-1, sdata = shifter bits MSB-first.
//   - lrclk = 1 for slots SAMPLE_W..2*SAMPLE_W-1.
//  Frame period = 2*SAMPLE_W*2*BCLK_DIV clock cycles. The CPU must average at most one push per frame.
//  Flags: clr_flags clears both flags. If a flag event coincides with clr_flags, the event wins and the flag stays 1.
//  Reset during a frame: asynchronous return to the reset state with the FIFO contents discarded. No partial frame is resumed.
// STRUCTURE
//  audio_pkg
//   - typedef struct packed {logic [SAMPLE_W-1:0] left, right;} stereo_t
//   - typedef enum logic {IDLE, RUN} i2s_state_t
//   - localparam I2S_LEFT = 1'b0, I2S_RIGHT = 1'b1
//  Sub-module sync_fifo (DWIDTH, DEPTH): push, pop, dout, level, full, empty.
//  Top level holds the divider, bit counter, FSM, shifter and flags.
// TESTING (DEPTH=8, BCLK_DIV=2, SAMPLE_W=16)
//  1. Assert reset mid-stream -> same cycle: all outputs 0 and fifo_level=0. After release, outputs stay 0 while enable=0.
//  2. Push 32'hA5A5_0F0F, then enable=1 -> lrclk=0 for 16 BCLKs; sdata=0, then 0xA5A5 MSB-first from slot 1; lrclk=1 carries 0x0F0F; LSB=1 in slot 0 of the next frame. BCLK period = 4 clocks.
//  3. enable=1 with the FIFO empty -> sdata all 0 and underflow=1 from frame start. Pulse clr_flags -> underflow=0.
//  4. Push 9 words 1..9 with enable=0 -> fifo_level=8, overflow=1, word 9 absent. Then enable -> frames carry words 1..8 in order.
//  5. FIFO full, push coincident with a frame-boundary pop -> overflow stays 0 and fifo_level stays 8.
//  6. Drop enable mid-frame -> the current frame completes, then bclk, lrclk and sdata are all 0 from the next boundary, and no pop occurs.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types for the audio output path.
// Stereo sample layout, serialiser states, slot ids.
package audio_pkg;

   localparam int AUDIO_SAMPLE_W = 16;

   typedef struct packed {
      logic [AUDIO_SAMPLE_W-1:0] left;
      logic [AUDIO_SAMPLE_W-1:0] right;
   } stereo_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } i2s_state_t;

   localparam logic I2S_LEFT  = 1'b0;
   localparam logic I2S_RIGHT = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO.
// A full FIFO still accepts a push when a pop happens in the same cycle.
module sync_fifo #(
   parameter int DWIDTH = 32,
   parameter int DEPTH  = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DWIDTH-1:0]        din,
   output logic [DWIDTH-1:0]        dout,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [DWIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // storage write; contents need no reset, pointers define validity
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // pointer and occupancy tracking
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         level <= level + LW'(do_push) - LW'(do_pop);
      end
   end

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S stereo transmitter fed by a sample FIFO.
// Divider, bit counter, FSM, shifter and sticky flags.
module i2s_dac_tx
   import audio_pkg::*;
#(
   parameter int DWIDTH   = 32,
   parameter int SAMPLE_W = 16,
   parameter int DEPTH    = 8,
   parameter int BCLK_DIV = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [DWIDTH-1:0]        outport,
   input  logic                     output_valid,
   input  logic                     enable,
   input  logic                     clr_flags,
   output logic                     i2s_bclk,
   output logic                     i2s_lrclk,
   output logic                     i2s_sdata,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int BW = $clog2(2 * SAMPLE_W);
   localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(2 * SAMPLE_W - 1);
   localparam logic [BW-1:0] R_SLOT   = BW'(SAMPLE_W);
   localparam logic [DW-1:0] DIV_TC   = DW'(BCLK_DIV - 1);

   i2s_state_t        state;
   i2s_state_t        state_nxt;
   logic [DW-1:0]     divcnt;
   logic [BW-1:0]     bitcnt;
   logic [BW-1:0]     bit_nxt;
   logic [DWIDTH-1:0] shifter;
   logic [DWIDTH-1:0] fifo_dout;
   logic              fifo_full;
   logic              fifo_empty;
   logic              tc;
   logic              fall;
   logic              wrap;
   logic              frame_start;
   logic              ov_evt;
   logic              un_evt;
   stereo_t           sample;

   assign sample  = stereo_t'(fifo_dout);
   assign tc      = (divcnt == DIV_TC);
   assign fall    = (state == RUN) && tc && i2s_bclk;
   assign wrap    = fall && (bitcnt == LAST_BIT);
   assign bit_nxt = bitcnt + 1'b1;
   assign ov_evt  = output_valid && fifo_full
                    && !(frame_start && !fifo_empty);
   assign un_evt  = frame_start && fifo_empty;

   sync_fifo #(
      .DWIDTH (DWIDTH),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (output_valid),
      .pop   (frame_start),
      .din   (outport),
      .dout  (fifo_dout),
      .level (fifo_level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // next state; enable only matters on frame boundaries
   always_comb begin
      state_nxt   = state;
      frame_start = 1'b0;
      unique case (state)
         IDLE: begin
            if (enable) begin
               state_nxt   = RUN;
               frame_start = 1'b1;
            end
         end
         RUN: begin
            if (wrap) begin
               if (enable) frame_start = 1'b1;
               else        state_nxt   = IDLE;
            end
         end
      endcase
   end

   // divider, bit counter, shifter and line drivers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         divcnt    <= '0;
         bitcnt    <= '0;
         shifter   <= '0;
         i2s_bclk  <= 1'b0;
         i2s_lrclk <= I2S_LEFT;
         i2s_sdata <= 1'b0;
      end else if (state_nxt == IDLE) begin
         divcnt    <= '0;
         bitcnt    <= '0;
         shifter   <= '0;
         i2s_bclk  <= 1'b0;
         i2s_lrclk <= I2S_LEFT;
         i2s_sdata <= 1'b0;
      end else if (frame_start) begin
         divcnt    <= '0;
         bitcnt    <= '0;
         i2s_bclk  <= 1'b0;
         i2s_lrclk <= I2S_LEFT;
         // previous frame's right LSB goes out in slot 0
         i2s_sdata <= shifter[DWIDTH-1];
         if (fifo_empty) shifter <= '0;
         else            shifter <= {sample.left, sample.right};
      end else begin
         if (tc) begin
            divcnt   <= '0;
            i2s_bclk <= ~i2s_bclk;
         end else begin
            divcnt <= divcnt + 1'b1;
         end
         if (fall) begin
            bitcnt    <= bit_nxt;
            i2s_sdata <= shifter[DWIDTH-1];
            shifter   <= {shifter[DWIDTH-2:0], 1'b0};
            i2s_lrclk <= (bit_nxt >= R_SLOT) ? I2S_RIGHT : I2S_LEFT;
         end
      end
   end

   // sticky flags; a new event beats a clear in the same cycle
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= ov_evt | (overflow & ~clr_flags);
         underflow <= un_evt | (underflow & ~clr_flags);
      end
   end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: bit-level I2S receiver model
// plus directed vectors with hand-computed frame contents.
module tb_i2s_dac_tx;

   logic        clock;
   logic        reset;
   logic [31:0] outport;
   logic        output_valid;
   logic        enable;
   logic        clr_flags;
   logic        i2s_bclk;
   logic        i2s_lrclk;
   logic        i2s_sdata;
   logic [3:0]  fifo_level;
   logic        overflow;
   logic        underflow;

   int total;
   int bad;

   logic [1:0] bits[$];
   logic       prev_bclk;

   typedef struct {
      logic [31:0] word;
      logic [15:0] left;
      logic [15:0] right;
   } vec_t;

   vec_t vecs[9];

   i2s_dac_tx #(
      .DWIDTH   (32),
      .SAMPLE_W (16),
      .DEPTH    (8),
      .BCLK_DIV (2)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .outport      (outport),
      .output_valid (output_valid),
      .enable       (enable),
      .clr_flags    (clr_flags),
      .i2s_bclk     (i2s_bclk),
      .i2s_lrclk    (i2s_lrclk),
      .i2s_sdata    (i2s_sdata),
      .fifo_level   (fifo_level),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // receiver: capture {lrclk, sdata} at each bclk rise
   initial prev_bclk = 1'b0;
   always @(negedge clock) begin
      if (i2s_bclk && !prev_bclk)
         bits.push_back({i2s_lrclk, i2s_sdata});
      prev_bclk = i2s_bclk;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [5:0] pins();
      return {i2s_bclk, i2s_lrclk, i2s_sdata,
              overflow, underflow, fifo_level == 4'd0};
   endfunction

   task automatic get_frame(input int f,
                            input bit has_next,
                            output logic [15:0] l,
                            output logic [15:0] r,
                            output int lr_err,
                            output int ones);
      logic [1:0] b;
      bit exp_lr;
      l = '0;
      r = '0;
      lr_err = 0;
      ones = 0;
      for (int s = 0; s < 32; s++) begin
         b = bits[f*32+s];
         exp_lr = (s >= 16);
         if (b[1] !== exp_lr) lr_err++;
         if (s > 0 && b[0] === 1'b1) ones++;
         if (s >= 1 && s <= 16) l = {l[14:0], b[0]};
         else if (s >= 17) r = {r[14:0], b[0]};
      end
      b = has_next ? bits[(f+1)*32] : 2'b00;
      r = {r[14:0], b[0]};
   endtask

   initial begin
      logic [15:0] l;
      logic [15:0] r;
      logic [15:0] m;
      logic [1:0]  b0;
      int lr_err;
      int ones;

      vecs[0] = '{32'h0000_0001, 16'h0000, 16'h0001};
      vecs[1] = '{32'h0000_0002, 16'h0000, 16'h0002};
      vecs[2] = '{32'h0000_0003, 16'h0000, 16'h0003};
      vecs[3] = '{32'h0000_0004, 16'h0000, 16'h0004};
      vecs[4] = '{32'h0000_0005, 16'h0000, 16'h0005};
      vecs[5] = '{32'h0000_0006, 16'h0000, 16'h0006};
      vecs[6] = '{32'h0000_0007, 16'h0000, 16'h0007};
      vecs[7] = '{32'h0000_0008, 16'h0000, 16'h0008};
      vecs[8] = '{32'hDEAD_BEEF, 16'hDEAD, 16'hBEEF};

      total = 0;
      bad = 0;
      reset = 1'b0;
      outport = '0;
      output_valid = 1'b0;
      enable = 1'b0;
      clr_flags = 1'b0;

      // reset state
      ticks(2);
      @(negedge clock);
      check("reset pins", 32'(pins()), 32'h01);
      reset = 1'b1;
      ticks(3);
      @(negedge clock);
      check("idle pins", 32'(pins()), 32'h01);

      // single word frame with one-bit delay
      outport = 32'hA5A5_0F0F;
      output_valid = 1'b1;
      tick();
      output_valid = 1'b0;
      @(negedge clock);
      check("push level", 32'(fifo_level), 32'd1);
      bits.delete();
      enable = 1'b1;
      ticks(140);
      enable = 1'b0;
      ticks(160);
      @(negedge clock);
      check("t2 bit count", bits.size(), 64);
      get_frame(0, 1'b1, l, r, lr_err, ones);
      b0 = bits[0];
      check("t2 slot0", 32'(b0[0]), 32'd0);
      check("t2 left", 32'(l), 32'hA5A5);
      check("t2 right", 32'(r), 32'h0F0F);
      check("t2 lrclk", lr_err, 0);
      get_frame(1, 1'b0, l, r, lr_err, ones);
      check("t2 empty frame", ones, 0);
      check("t2 underflow", 32'(underflow), 32'd1);
      check("t2 idle pins", 32'(pins() & 6'b111001), 32'h01);

      // empty FIFO start, then clear
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      @(negedge clock);
      check("clr underflow", 32'(underflow), 32'd0);
      bits.delete();
      enable = 1'b1;
      tick();
      enable = 1'b0;
      @(negedge clock);
      check("t3 underflow", 32'(underflow), 32'd1);
      ticks(150);
      @(negedge clock);
      check("t3 bit count", bits.size(), 32);
      get_frame(0, 1'b0, l, r, lr_err, ones);
      check("t3 zero data", ones, 0);
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      @(negedge clock);
      check("t3 clr", 32'(underflow), 32'd0);

      // overfill with enable low
      for (int i = 1; i <= 9; i++) begin
         outport = 32'(i);
         output_valid = 1'b1;
         tick();
      end
      output_valid = 1'b0;
      @(negedge clock);
      check("t4 level", 32'(fifo_level), 32'd8);
      check("t4 overflow", 32'(overflow), 32'd1);
      outport = 32'h0000_00FF;
      output_valid = 1'b1;
      clr_flags = 1'b1;
      tick();
      output_valid = 1'b0;
      clr_flags = 1'b0;
      @(negedge clock);
      check("ovf beats clr", 32'(overflow), 32'd1);
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      @(negedge clock);
      check("clr overflow", 32'(overflow), 32'd0);

      // push coincident with boundary pop on a full FIFO
      bits.delete();
      enable = 1'b1;
      outport = vecs[8].word;
      output_valid = 1'b1;
      tick();
      output_valid = 1'b0;
      @(negedge clock);
      check("t5 level", 32'(fifo_level), 32'd8);
      check("t5 overflow", 32'(overflow), 32'd0);
      ticks(8*128 + 10);
      enable = 1'b0;
      ticks(170);
      @(negedge clock);
      check("t5 bit count", bits.size(), 288);
      for (int f = 0; f < 9; f++) begin
         get_frame(f, f < 8, l, r, lr_err, ones);
         m = (f < 8) ? 16'hFFFF : 16'hFFFE;
         check($sformatf("t5 f%0d left", f),
               32'(l), 32'(vecs[f].left));
         check($sformatf("t5 f%0d right", f),
               32'(r & m), 32'(vecs[f].right & m));
         check($sformatf("t5 f%0d lrclk", f), lr_err, 0);
      end
      check("t6 idle pins", 32'(pins()), 32'h01);
      bits.delete();
      ticks(40);
      @(negedge clock);
      check("t6 no bclk", bits.size(), 0);

      // asynchronous reset mid-stream
      outport = 32'h1234_5678;
      output_valid = 1'b1;
      tick();
      outport = 32'h9ABC_DEF0;
      tick();
      output_valid = 1'b0;
      enable = 1'b1;
      ticks(50);
      @(negedge clock);
      check("t1 pre level", 32'(fifo_level), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("t1 async pins", 32'(pins()), 32'h01);
      tick();
      enable = 1'b0;
      reset = 1'b1;
      bits.delete();
      ticks(20);
      @(negedge clock);
      check("t1 post pins", 32'(pins()), 32'h01);
      check("t1 post bclk", bits.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
